// File: rtl/axis_bram_pkg.sv
// Shared definitions for the BRAM-to-AXI4-Stream playback engine: FSM encoding,
// BRAM timing and the read-credit rule that keeps the output FIFO from overflowing.
package axis_bram_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int unsigned BRAM_RD_LATENCY = 1;
  localparam int unsigned FIFO_DEPTH      = 2;

  // A read may be issued only if every word already owed to the FIFO still fits after
  // this cycle's pop.
  function automatic logic issue_allowed(input logic [1:0] fifo_count,
                                         input logic       inflight,
                                         input logic       pop);
    logic [2:0] occupancy;
    occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    return occupancy < 3'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry FIFO holding {tlast, addr, data} between the BRAM read port and the stream
// master; head entry is presented combinationally.
module axis_skid_fifo2 #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 2'd1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != 2'd0);
  assign count      = count_q;

endmodule

// File: rtl/axis_bram_streamer.sv
// Plays a BRAM buffer from address 0 to a captured last address on an AXI4-Stream master,
// once or looping back-to-back, with credit-based reads into a two-entry output FIFO.
module axis_bram_streamer
  import axis_bram_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned BRAM_DATA_WIDTH  = 32,
  parameter int unsigned BRAM_ADDR_WIDTH  = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_last,
  input  logic                        cfg_cont,
  input  logic                        enable,
  output logic [BRAM_ADDR_WIDTH-1:0]  sts_data,
  output logic                        busy,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        bram_portb_clk,
  output logic                        bram_portb_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_portb_rddata
);

  localparam int unsigned ENTRY_WIDTH = 1 + BRAM_ADDR_WIDTH + BRAM_DATA_WIDTH;

  logic [1:0]                 state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BRAM_ADDR_WIDTH-1:0] last_q, last_d;
  logic                       cont_q, cont_d;

  // Read issued last cycle; its data is on bram_portb_rddata this cycle.
  logic                       inflight_q;
  logic [BRAM_ADDR_WIDTH-1:0] inflight_addr_q;
  logic                       inflight_last_q;

  logic [ENTRY_WIDTH-1:0]     fifo_push_data;
  logic [ENTRY_WIDTH-1:0]     fifo_head;
  logic                       fifo_valid;
  logic [1:0]                 fifo_count;

  logic                       head_last;
  logic [BRAM_ADDR_WIDTH-1:0] head_addr;
  logic [BRAM_DATA_WIDTH-1:0] head_data;

  logic                       pop;
  logic                       issue;
  logic                       issue_last;
  logic                       final_pop;

  assign pop        = m_axis_tvalid && m_axis_tready;
  assign issue      = (state_q == ST_READ) && issue_allowed(fifo_count, inflight_q, pop);
  assign issue_last = issue && (addr_q == last_q);

  // Nothing is issued in DRAIN, so the only word left owed is the frame's final one.
  assign final_pop  = pop && (({1'b0, fifo_count} + {2'b00, inflight_q}) == 3'd1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    cont_d  = cont_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_READ;
          addr_d  = '0;
          last_d  = cfg_last;
          cont_d  = cfg_cont;
        end
      end
      ST_READ: begin
        if (issue_last) begin
          addr_d = '0;
          // Looping restarts on the same edge so the next frame follows without a bubble.
          if (cont_q && enable) begin
            last_d = cfg_last;
            cont_d = cfg_cont;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (issue) begin
          addr_d = addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (final_pop) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      last_q          <= '0;
      cont_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      last_q          <= last_d;
      cont_q          <= cont_d;
      inflight_q      <= issue;
      inflight_addr_q <= addr_q;
      inflight_last_q <= issue_last;
    end
  end

  assign fifo_push_data = {inflight_last_q, inflight_addr_q, bram_portb_rddata};

  axis_skid_fifo2 #(
    .DATA_WIDTH(ENTRY_WIDTH)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (inflight_q),
    .push_data (fifo_push_data),
    .pop       (pop),
    .head_data (fifo_head),
    .head_valid(fifo_valid),
    .count     (fifo_count)
  );

  assign {head_last, head_addr, head_data} = fifo_head;

  assign m_axis_tvalid   = fifo_valid;
  assign m_axis_tlast    = head_last;
  assign m_axis_tdata    = AXIS_TDATA_WIDTH'(head_data);
  assign sts_data        = head_addr;
  assign busy            = (state_q != ST_IDLE);

  assign bram_portb_clk  = aclk;
  assign bram_portb_rst  = ~aresetn;
  assign bram_portb_addr = addr_q;

endmodule

// File: tb/tb_axis_bram_streamer.sv
// Self-checking bench for axis_bram_streamer: BRAM model, stream monitor and a frame-level
// reference model of the expected word sequence.
module tb_axis_bram_streamer;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          aclk;
  logic          aresetn;
  logic [AW-1:0] cfg_last;
  logic          cfg_cont;
  logic          enable;
  logic [AW-1:0] sts_data;
  logic          busy;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          bram_portb_clk;
  logic          bram_portb_rst;
  logic [AW-1:0] bram_portb_addr;
  logic [DW-1:0] bram_portb_rddata;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [AW-1:0] addr;
    logic          busy;
    int            cyc;
  } word_t;

  typedef struct {
    int last;
    int pct;
    bit rnd_mem;
    int exp_words;
  } vec_t;

  word_t         obs_q[$];
  word_t         exp_q[$];
  logic [DW-1:0] mem [DEPTH];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            ready_pct = 100;
  int            cyc = 0;

  axis_bram_streamer #(
    .AXIS_TDATA_WIDTH(DW),
    .BRAM_DATA_WIDTH (DW),
    .BRAM_ADDR_WIDTH (AW)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .cfg_last         (cfg_last),
    .cfg_cont         (cfg_cont),
    .enable           (enable),
    .sts_data         (sts_data),
    .busy             (busy),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tready    (m_axis_tready),
    .bram_portb_clk   (bram_portb_clk),
    .bram_portb_rst   (bram_portb_rst),
    .bram_portb_addr  (bram_portb_addr),
    .bram_portb_rddata(bram_portb_rddata)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial bram_portb_rddata = '0;
  always @(posedge aclk) bram_portb_rddata <= mem[bram_portb_addr];

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = ($urandom_range(99) < ready_pct);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: records every handshake and checks AXIS hold-while-stalled.
  initial begin : monitor
    logic               stall;
    logic [DW+AW:0]     held;
    word_t              w;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold", {m_axis_tvalid, m_axis_tlast, sts_data, m_axis_tdata}, {1'b1, held});
        end
        if (m_axis_tvalid && m_axis_tready) begin
          w.data = m_axis_tdata;
          w.last = m_axis_tlast;
          w.addr = sts_data;
          w.busy = busy;
          w.cyc  = cyc;
          obs_q.push_back(w);
        end
        stall = m_axis_tvalid && !m_axis_tready;
        held  = {m_axis_tlast, sts_data, m_axis_tdata};
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < DEPTH; i++) mem[i] = rnd ? DW'($urandom) : DW'(i + 100);
  endtask

  // Reference model: a frame is words 0..L in order, tlast only on L.
  task automatic add_frame(input int l);
    word_t w;
    for (int a = 0; a <= l; a++) begin
      w.data = mem[a];
      w.last = (a == l);
      w.addr = AW'(a);
      w.busy = 1'b1;
      w.cyc  = 0;
      exp_q.push_back(w);
    end
  endtask

  task automatic compare_streams(input bit gapless);
    int n;
    int gaps;
    check("word_count", 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("word%0d", i),
            {obs_q[i].busy, obs_q[i].last, obs_q[i].addr, obs_q[i].data},
            {exp_q[i].busy, exp_q[i].last, exp_q[i].addr, exp_q[i].data});
    end
    if (gapless) begin
      gaps = 0;
      for (int i = 1; i < obs_q.size(); i++) begin
        if (obs_q[i].cyc != obs_q[i-1].cyc + 1) gaps++;
      end
      check("gapless", 64'(gaps), 64'd0);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_obs(input int n, input int max);
    int k = 0;
    while (obs_q.size() < n && k < max) begin
      tick();
      k++;
    end
    check("obs_timeout", {63'd0, obs_q.size() >= n}, 64'd1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_tvalid"}, {63'd0, m_axis_tvalid}, 64'd0);
    check({tag, "_tlast"}, {63'd0, m_axis_tlast}, 64'd0);
    check({tag, "_tdata"}, 64'(m_axis_tdata), 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_sts"}, 64'(sts_data), 64'd0);
    check({tag, "_addr"}, 64'(bram_portb_addr), 64'd0);
    check({tag, "_portb_rst"}, {63'd0, bram_portb_rst}, 64'd1);
  endtask

  vec_t vecs[7];
  int   n;
  int   m;

  initial begin
    vecs[0] = '{last: 7,    pct: 100, rnd_mem: 1'b0, exp_words: 8};
    vecs[1] = '{last: 7,    pct: 50,  rnd_mem: 1'b0, exp_words: 8};
    vecs[2] = '{last: 0,    pct: 40,  rnd_mem: 1'b1, exp_words: 1};
    vecs[3] = '{last: 1023, pct: 100, rnd_mem: 1'b1, exp_words: 1024};
    vecs[4] = '{last: 12,   pct: 30,  rnd_mem: 1'b1, exp_words: 13};
    vecs[5] = '{last: 63,   pct: 70,  rnd_mem: 1'b0, exp_words: 64};
    vecs[6] = '{last: 2,    pct: 25,  rnd_mem: 1'b1, exp_words: 3};

    aresetn  = 1'b0;
    cfg_last = '0;
    cfg_cont = 1'b0;
    enable   = 1'b0;
    fill_mem(1'b0);
    repeat (3) @(posedge aclk);
    #1;
    check_cleared("reset");
    aresetn = 1'b1;
    tick();
    check("portb_rst_released", {63'd0, bram_portb_rst}, 64'd0);

    // Latency: enable sampled at edge 0, addr 0 after edge 0, tvalid after edge 2.
    cfg_last = 10'd7;
    cfg_cont = 1'b0;
    enable   = 1'b1;
    tick();
    enable = 1'b0;
    check("lat_e0_busy", {63'd0, busy}, 64'd1);
    check("lat_e0_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("lat_e0_addr", 64'(bram_portb_addr), 64'd0);
    tick();
    check("lat_e1_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("lat_e1_addr", 64'(bram_portb_addr), 64'd1);
    tick();
    check("lat_e2_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    check("lat_e2_word", {m_axis_tlast, sts_data, m_axis_tdata}, {1'b0, 10'd0, 32'd100});
    add_frame(7);
    wait_idle(200);
    tick();
    compare_streams(1'b1);
    check("lat_end_tvalid", {63'd0, m_axis_tvalid}, 64'd0);

    // One-shot frames under assorted tready patterns and buffer contents.
    for (int v = 0; v < 7; v++) begin
      fill_mem(vecs[v].rnd_mem);
      ready_pct = vecs[v].pct;
      cfg_last  = AW'(vecs[v].last);
      cfg_cont  = 1'b0;
      enable    = 1'b1;
      tick();
      enable = 1'b0;
      wait_idle(20000);
      repeat (2) tick();
      check($sformatf("vec%0d_words", v), 64'(obs_q.size()), 64'(vecs[v].exp_words));
      add_frame(vecs[v].last);
      compare_streams(vecs[v].pct == 100);
      if (vecs[v].last == DEPTH - 1) begin
        check("wrap_addr", 64'(bram_portb_addr), 64'd0);
      end
    end
    ready_pct = 100;

    // Reset while a frame is being presented.
    fill_mem(1'b0);
    cfg_last = 10'd7;
    enable   = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    tick();
    check("rst_pre_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    aresetn = 1'b0;
    #1;
    check_cleared("midrst");
    tick();
    aresetn = 1'b1;
    repeat (4) tick();
    check("post_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    obs_q.delete();
    exp_q.delete();

    // Continuous: three frames, enable dropped during the fourth.
    cfg_last = 10'd3;
    cfg_cont = 1'b1;
    enable   = 1'b1;
    wait_obs(13, 200);
    enable = 1'b0;
    wait_idle(200);
    tick();
    for (int f = 0; f < 4; f++) add_frame(3);
    compare_streams(1'b1);

    // Continuous single-word frames.
    cfg_last = 10'd0;
    cfg_cont = 1'b1;
    enable   = 1'b1;
    wait_obs(6, 200);
    enable = 1'b0;
    wait_idle(200);
    tick();
    n = obs_q.size();
    check("l0_count_range", {63'd0, (n >= 6) && (n <= 9)}, 64'd1);
    for (int f = 0; f < n; f++) add_frame(0);
    compare_streams(1'b1);

    // cfg_last changed mid-frame only affects the following frame.
    cfg_last = 10'd7;
    cfg_cont = 1'b1;
    enable   = 1'b1;
    wait_obs(4, 200);
    cfg_last = 10'd2;
    wait_obs(6, 200);
    enable = 1'b0;
    wait_idle(200);
    tick();
    n = obs_q.size();
    check("reframe_count", {63'd0, (n >= 11) && (((n - 8) % 3) == 0)}, 64'd1);
    m = (n >= 11) ? (n - 8) / 3 : 0;
    add_frame(7);
    for (int f = 0; f < m; f++) add_frame(2);
    compare_streams(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
